pll_reconfig_seq: RTL and testbench

PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

---
 rtl/pllrc_pkg.sv | 25 ++
 rtl/pll_reconfig_seq.sv | 185 ++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pllrc_pkg.sv
// Shared constants for the PLL reconfiguration sequencer: pll_cfg register map
// and the sequencer state encoding.
package pllrc_pkg;

   localparam logic [5:0] ADDR_MODE  = 6'd0;
   localparam logic [5:0] ADDR_START = 6'd2;
   localparam logic [5:0] ADDR_N     = 6'd3;
   localparam logic [5:0] ADDR_M     = 6'd4;
   localparam logic [5:0] ADDR_C     = 6'd5;
   localparam logic [5:0] ADDR_K     = 6'd7;
   localparam logic [5:0] ADDR_BW    = 6'd8;
   localparam logic [5:0] ADDR_CP    = 6'd9;

   localparam logic [31:0] N_BYPASS = 32'h0001_0000;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      GAP  = 3'd2,
      PRST = 3'd3,
      LOCK = 3'd4,
      FIN  = 3'd5
   } state_t;

endpackage

// File: rtl/pll_reconfig_seq.sv
// Writes the eight pll_cfg registers over Avalon-MM, pulses pll_reset, then waits for lock.
// Optional watchdog in WR and LOCK enabled by defining RECFG_TIMEOUT_EN.
module pll_reconfig_seq
   import pllrc_pkg::*;
#(
   parameter int unsigned CP_VAL     = 1,
   parameter int unsigned BW_VAL     = 7,
   parameter int          RST_CYCLES = 8,
   parameter int          TIMEOUT    = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] m_val,
   input  logic [31:0] k_val,
   input  logic [31:0] c0_val,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        mgmt_write,
   input  logic        mgmt_waitrequest,
   input  logic        locked,
   output logic        pll_reset
);

   if (RST_CYCLES < 1 || RST_CYCLES > 255 || TIMEOUT < 1) begin : g_bad_param
      $error("pll_reconfig_seq: RST_CYCLES must be 1..255 and TIMEOUT >= 1");
   end

   state_t      state;
   state_t      next_state;
   logic [2:0]  idx;
   logic [31:0] m_q;
   logic [31:0] k_q;
   logic [31:0] c0_q;
   logic [7:0]  rst_cnt;
   logic        lock_meta;
   logic        lock_sync;
   logic        tmo_expired;
   logic        lock_ok;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;

   // Locked is only trusted once the registered pll_reset has actually dropped.
   assign lock_ok = lock_sync && !pll_reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) next_state = WR;
         end
         WR: begin
            if (!mgmt_waitrequest) next_state = GAP;
            else if (tmo_expired)  next_state = FIN;
         end
         GAP: begin
            next_state = (idx == 3'd7) ? PRST : WR;
         end
         PRST: begin
            if (rst_cnt == 8'd0) next_state = LOCK;
         end
         LOCK: begin
            if (lock_ok)          next_state = FIN;
            else if (tmo_expired) next_state = FIN;
         end
         FIN: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      wr_addr = ADDR_MODE;
      wr_data = 32'd0;
      case (idx)
         3'd0: begin wr_addr = ADDR_MODE;  wr_data = 32'd0;          end
         3'd1: begin wr_addr = ADDR_M;     wr_data = m_q;            end
         3'd2: begin wr_addr = ADDR_K;     wr_data = k_q;            end
         3'd3: begin wr_addr = ADDR_N;     wr_data = N_BYPASS;       end
         3'd4: begin wr_addr = ADDR_C;     wr_data = c0_q;           end
         3'd5: begin wr_addr = ADDR_CP;    wr_data = 32'(CP_VAL);    end
         3'd6: begin wr_addr = ADDR_BW;    wr_data = 32'(BW_VAL);    end
         3'd7: begin wr_addr = ADDR_START; wr_data = 32'd0;          end
         default: begin wr_addr = ADDR_MODE; wr_data = 32'd0;        end
      endcase
   end

   always_comb begin
      busy           = (state != IDLE);
      done           = (state == FIN);
      mgmt_write     = (state == WR);
      mgmt_address   = (state == WR) ? wr_addr : 6'd0;
      mgmt_writedata = (state == WR) ? wr_data : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx  <= 3'd0;
         m_q  <= 32'd0;
         k_q  <= 32'd0;
         c0_q <= 32'd0;
      end else if (state == IDLE && start) begin
         idx  <= 3'd0;
         m_q  <= m_val;
         k_q  <= k_val;
         c0_q <= c0_val;
      end else if (state == GAP) begin
         idx <= idx + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rst_cnt   <= 8'd0;
         pll_reset <= 1'b0;
      end else begin
         pll_reset <= (state == PRST);
         if (state == GAP && next_state == PRST) begin
            rst_cnt <= 8'(RST_CYCLES - 1);
         end else if (state == PRST && rst_cnt != 8'd0) begin
            rst_cnt <= rst_cnt - 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_meta <= 1'b0;
         lock_sync <= 1'b0;
      end else begin
         lock_meta <= locked;
         lock_sync <= lock_meta;
      end
   end

`ifdef RECFG_TIMEOUT_EN
   logic [31:0] tmo_cnt;
   logic        tmo_fire;
   logic        error_q;

   assign tmo_expired = (tmo_cnt == 32'd0);
   assign tmo_fire    = tmo_expired &&
                        ((state == WR && mgmt_waitrequest) || (state == LOCK && !lock_ok));
   assign error       = error_q;

   // Reloaded on every entry into a waiting state, so each write gets its own budget.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt <= 32'd0;
      end else if (next_state != state && (next_state == WR || next_state == LOCK)) begin
         tmo_cnt <= 32'(TIMEOUT - 1);
      end else if ((state == WR || state == LOCK) && tmo_cnt != 32'd0) begin
         tmo_cnt <= tmo_cnt - 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         error_q <= 1'b0;
      end else if (state == IDLE && start) begin
         error_q <= 1'b0;
      end else if (tmo_fire) begin
         error_q <= 1'b1;
      end
   end
`else
   assign tmo_expired = 1'b0;
   assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: vector table of full sequences plus reset corner cases.
module tb_pll_reconfig_seq;
   import pllrc_pkg::*;

   localparam int RST = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] m_val, k_val, c0_val;
   logic        busy, done, error;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        mgmt_write;
   logic        mgmt_waitrequest;
   logic        locked;
   logic        pll_reset;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pll_reconfig_seq #(
      .CP_VAL(1), .BW_VAL(7), .RST_CYCLES(RST), .TIMEOUT(100)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .m_val(m_val), .k_val(k_val), .c0_val(c0_val),
      .busy(busy), .done(done), .error(error),
      .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
      .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
      .locked(locked), .pll_reset(pll_reset)
   );

   typedef struct {
      logic [31:0] m;
      logic [31:0] k;
      logic [31:0] c0;
      int          stall_idx;
      int          stall_len;
      int          lock_mode;
      int          start2_cyc;
      int          exp_done;
      int          exp_wr_hi;
   } vec_t;

   vec_t vecs[5];

   logic [5:0]  got_addr[$];
   logic [31:0] got_data[$];
   int done_cyc, done_cnt, prst_cnt, wr_hi;
   logic stable_ok, busy1, busy_after, err_c1, err_done, err_after;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // lock_mode: 0 locked stays high, 1 drops during PRST and returns 40 cycles after it, 2 held low
   task automatic applyStimulus(input vec_t v);
      int stall = 0;
      int prst_end = -1;
      logic [5:0]  hold_a = '0;
      logic [31:0] hold_d = '0;
      got_addr.delete();
      got_data.delete();
      done_cyc = -1; done_cnt = 0; prst_cnt = 0; wr_hi = 0;
      stable_ok = 1'b1; busy1 = 1'b0; busy_after = 1'b1;
      err_c1 = 1'b1; err_done = 1'b0; err_after = 1'b0;
      @(negedge clk);
      m_val = v.m; k_val = v.k; c0_val = v.c0;
      if (v.lock_mode == 2) locked = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc > 0) @(negedge clk);
         start = (cyc == 0) || (cyc == v.start2_cyc);
         if (cyc == v.start2_cyc) begin
            m_val = ~v.m; k_val = ~v.k; c0_val = ~v.c0;
         end
         if (cyc == 1) begin busy1 = busy; err_c1 = error; end
         if (pll_reset) begin
            prst_cnt++;
            if (v.lock_mode == 1) locked = 1'b0;
         end else if (prst_cnt > 0 && prst_end < 0) begin
            prst_end = cyc;
         end
         if (v.lock_mode == 1 && prst_end >= 0 && cyc == prst_end + 40) locked = 1'b1;
         mgmt_waitrequest = 1'b0;
         if (mgmt_write) begin
            wr_hi++;
            if (got_addr.size() == v.stall_idx && stall < v.stall_len) begin
               if (stall == 0) begin
                  hold_a = mgmt_address; hold_d = mgmt_writedata;
               end else if (mgmt_address !== hold_a || mgmt_writedata !== hold_d) begin
                  stable_ok = 1'b0;
               end
               mgmt_waitrequest = 1'b1;
               stall++;
            end else begin
               if (got_addr.size() == v.stall_idx && stall > 0 &&
                   (mgmt_address !== hold_a || mgmt_writedata !== hold_d)) stable_ok = 1'b0;
               got_addr.push_back(mgmt_address);
               got_data.push_back(mgmt_writedata);
            end
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = cyc; err_done = error; end
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin busy_after = busy; err_after = error; end
         if (done_cyc >= 0 && cyc == done_cyc + 2) break;
      end
      start = 1'b0;
      mgmt_waitrequest = 1'b0;
      locked = 1'b1;
   endtask

   task automatic runVector(input vec_t v, input string tag);
      logic [5:0]  ea[8];
      logic [31:0] ed[8];
      ea = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
      ed = '{32'd0, v.m, v.k, 32'h10000, v.c0, 32'd1, 32'd7, 32'd0};
      applyStimulus(v);
      checkOutput({tag, " done_cycle"}, done_cyc, v.exp_done);
      checkOutput({tag, " done_pulses"}, done_cnt, 1);
      checkOutput({tag, " pll_reset_cycles"}, prst_cnt, RST);
      checkOutput({tag, " write_count"}, got_addr.size(), 8);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("%s write%0d_addr", tag, i),
                     (i < got_addr.size()) ? 64'(got_addr[i]) : 64'hBAD, 64'(ea[i]));
         checkOutput($sformatf("%s write%0d_data", tag, i),
                     (i < got_data.size()) ? 64'(got_data[i]) : 64'hBAD, 64'(ed[i]));
      end
      checkOutput({tag, " write_high_cycles"}, wr_hi, v.exp_wr_hi);
      checkOutput({tag, " stall_stable"}, stable_ok, 1'b1);
      checkOutput({tag, " busy_after_start"}, busy1, 1'b1);
      checkOutput({tag, " busy_after_done"}, busy_after, 1'b0);
      checkOutput({tag, " error_cleared"}, err_c1, 1'b0);
      checkOutput({tag, " error_at_done"}, err_done, 1'b0);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " busy"}, busy, 1'b0);
      checkOutput({tag, " done"}, done, 1'b0);
      checkOutput({tag, " error"}, error, 1'b0);
      checkOutput({tag, " mgmt_write"}, mgmt_write, 1'b0);
      checkOutput({tag, " pll_reset"}, pll_reset, 1'b0);
      checkOutput({tag, " mgmt_address"}, mgmt_address, 6'd0);
      checkOutput({tag, " mgmt_writedata"}, mgmt_writedata, 32'd0);
   endtask

   initial begin
      vec_t hv;
      vecs[0] = '{32'h404, 32'hA3D709E8, 32'h20201, -1, 0, 0, -1, 27, 8};
      vecs[1] = '{32'h404, 32'hA3D709E8, 32'h20201, 3, 5, 0, -1, 32, 13};
      vecs[2] = '{32'h12345678, 32'h0, 32'hFFFFFFFF, -1, 0, 0, 20, 27, 8};
      vecs[3] = '{32'h1, 32'h2, 32'h3, -1, 0, 1, -1, 69, 8};
      vecs[4] = '{32'hCAFE0001, 32'h5555AAAA, 32'h00010001, 7, 3, 0, -1, 30, 11};

      reset = 1'b1; start = 1'b0; mgmt_waitrequest = 1'b0; locked = 1'b1;
      m_val = '0; k_val = '0; c0_val = '0;
      repeat (3) @(negedge clk);
      checkIdle("reset");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkIdle("idle");

      for (int i = 0; i < 5; i++) runVector(vecs[i], $sformatf("vec%0d", i));

      // Reset while index 4 is on the bus, then a clean restart from address 0
      @(negedge clk);
      m_val = 32'h777; start = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checkOutput("midwrite addr_idx4", mgmt_address, ADDR_C);
      checkOutput("midwrite write_high", mgmt_write, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midwrite_rst mgmt_write", mgmt_write, 1'b0);
      checkOutput("midwrite_rst pll_reset", pll_reset, 1'b0);
      checkOutput("midwrite_rst busy", busy, 1'b0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      hv = '{32'h0BADF00D, 32'h11112222, 32'h33334444, -1, 0, 0, -1, 27, 8};
      runVector(hv, "restart");

      // Reset while pll_reset is asserted
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checkOutput("midprst pll_reset_high", pll_reset, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midprst_rst pll_reset", pll_reset, 1'b0);
      checkOutput("midprst_rst busy", busy, 1'b0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

`ifdef RECFG_TIMEOUT_EN
      hv = '{32'h404, 32'hA3D709E8, 32'h20201, -1, 0, 2, -1, 125, 8};
      applyStimulus(hv);
      checkOutput("timeout done_cycle", done_cyc, 125);
      checkOutput("timeout done_pulses", done_cnt, 1);
      checkOutput("timeout error_at_done", err_done, 1'b1);
      checkOutput("timeout error_sticky", err_after, 1'b1);
      runVector(vecs[0], "after_timeout");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
